// File: rtl/vx_pending_counter_pkg.sv
// rtl/vx_pending_counter_pkg.sv - shared widths and helpers for the pending counter
package vx_pending_counter_pkg;

    // Guard bits so count + incr - decr can go above SIZE or below zero without wrapping.
    localparam int NEXT_GUARD = 2;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/vx_pending_counter_if.sv
// rtl/vx_pending_counter_if.sv - per-channel incr/decr/flush and status bundle
interface vx_pending_counter_if #(
    parameter int NUM_CH = 1,
    parameter int SIZEW  = 3,
    parameter int INCRW  = 1
);
    logic [NUM_CH*INCRW-1:0] incr;
    logic [NUM_CH*INCRW-1:0] decr;
    logic [NUM_CH-1:0]       flush;
    logic [NUM_CH*SIZEW-1:0] size;
    logic [NUM_CH-1:0]       empty;
    logic [NUM_CH-1:0]       full;
    logic [NUM_CH-1:0]       alm_empty;
    logic [NUM_CH-1:0]       alm_full;
    logic [NUM_CH-1:0]       ovf_err;
    logic [NUM_CH-1:0]       udf_err;

    modport master (
        output incr, decr, flush,
        input  size, empty, full, alm_empty, alm_full, ovf_err, udf_err
    );

    modport slave (
        input  incr, decr, flush,
        output size, empty, full, alm_empty, alm_full, ovf_err, udf_err
    );
endinterface

// File: rtl/vx_pending_counter_ch.sv
// rtl/vx_pending_counter_ch.sv - one channel: saturating count, registered flags, sticky errors
module vx_pending_counter_ch
    import vx_pending_counter_pkg::*;
#(
    parameter int SIZE      = 4,
    parameter int MAX_INCR  = 1,
    parameter int ALM_FULL  = SIZE - 1,
    parameter int ALM_EMPTY = 1,
    localparam int SIZEW    = cnt_width(SIZE),
    localparam int INCRW    = cnt_width(MAX_INCR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INCRW-1:0] incr_i,
    input  logic [INCRW-1:0] decr_i,
    input  logic             flush_i,
    output logic [SIZEW-1:0] size_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             alm_empty_o,
    output logic             alm_full_o,
    output logic             ovf_err_o,
    output logic             udf_err_o
);
    localparam int NW = SIZEW + NEXT_GUARD;
    localparam logic signed [NW-1:0] SIZE_S = NW'(SIZE);

    logic [SIZEW-1:0]     cnt_q, cnt_d;
    logic                 empty_q, full_q, alm_empty_q, alm_full_q;
    logic                 ovf_q, ovf_d, udf_q, udf_d;
    logic signed [NW-1:0] next_s;

    assign next_s = $signed(NW'(cnt_q)) + $signed(NW'(incr_i)) - $signed(NW'(decr_i));

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (next_s > SIZE_S) begin
            cnt_d = SIZEW'(SIZE);
            ovf_d = 1'b1;
        end else if (next_s[NW-1]) begin
            cnt_d = '0;
            udf_d = 1'b1;
        end else begin
            cnt_d = next_s[SIZEW-1:0];
        end
    end

    // Flags come from cnt_d so they line up with the size they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            alm_empty_q <= 1'b1;
            alm_full_q  <= (ALM_FULL == 0);
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            empty_q     <= (cnt_d == '0);
            full_q      <= (cnt_d == SIZEW'(SIZE));
            alm_empty_q <= (cnt_d <= SIZEW'(ALM_EMPTY));
            alm_full_q  <= (cnt_d >= SIZEW'(ALM_FULL));
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (incr_i > INCRW'(MAX_INCR) || decr_i > INCRW'(MAX_INCR))
                $warning("vx_pending_counter_ch: amount above MAX_INCR");
            if (!flush_i && next_s > SIZE_S)
                $warning("vx_pending_counter_ch: overflow clamped");
            if (!flush_i && next_s[NW-1])
                $warning("vx_pending_counter_ch: underflow clamped");
        end
    end

    assign size_o      = cnt_q;
    assign empty_o     = empty_q;
    assign full_o      = full_q;
    assign alm_empty_o = alm_empty_q;
    assign alm_full_o  = alm_full_q;
    assign ovf_err_o   = ovf_q;
    assign udf_err_o   = udf_q;

endmodule

// File: rtl/vx_pending_counter.sv
// rtl/vx_pending_counter.sv - multi-channel pending-request tracker, one counter per channel
module vx_pending_counter
    import vx_pending_counter_pkg::*;
#(
    parameter int NUM_CH    = 1,
    parameter int SIZE      = 4,
    parameter int MAX_INCR  = 1,
    parameter int ALM_FULL  = SIZE - 1,
    parameter int ALM_EMPTY = 1,
    localparam int SIZEW    = cnt_width(SIZE),
    localparam int INCRW    = cnt_width(MAX_INCR)
) (
    input  logic                  clk,
    input  logic                  reset,
    vx_pending_counter_if.slave   cnt_if
);

    if (!(ALM_EMPTY < ALM_FULL && ALM_FULL <= SIZE && MAX_INCR >= 1 && MAX_INCR <= SIZE))
    begin : g_bad_params
        $error("vx_pending_counter: illegal SIZE/MAX_INCR/ALM_* combination");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        vx_pending_counter_ch #(
            .SIZE      (SIZE),
            .MAX_INCR  (MAX_INCR),
            .ALM_FULL  (ALM_FULL),
            .ALM_EMPTY (ALM_EMPTY)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .incr_i      (cnt_if.incr[i*INCRW +: INCRW]),
            .decr_i      (cnt_if.decr[i*INCRW +: INCRW]),
            .flush_i     (cnt_if.flush[i]),
            .size_o      (cnt_if.size[i*SIZEW +: SIZEW]),
            .empty_o     (cnt_if.empty[i]),
            .full_o      (cnt_if.full[i]),
            .alm_empty_o (cnt_if.alm_empty[i]),
            .alm_full_o  (cnt_if.alm_full[i]),
            .ovf_err_o   (cnt_if.ovf_err[i]),
            .udf_err_o   (cnt_if.udf_err[i])
        );
    end

endmodule
